// File: rtl/encoder_4x2_seq.sv
// Registered 4-to-2 request encoder with pending capture, valid/ack handshake and grant timeout.
// Define ENC_ROUND_ROBIN_EN for rotating priority; the default build uses fixed lowest-index priority.
module encoder_4x2_seq #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [0:3] D,
  input  logic       ack,
  output logic       A,
  output logic       B,
  output logic       valid,
  output logic [0:3] pending,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [0:3]       pending_q, pending_d;
  logic [0:3]       clr;
  logic [1:0]       sel_idx;
  logic             sel_any;

  assign sel_any = |pending_q;

`ifdef ENC_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;

  // Walk from farthest to nearest so the candidate closest to the pointer wins.
  always_comb begin
    sel_idx = ptr_q;
    cand    = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (pending_q[cand]) sel_idx = cand;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StGrant && (ack || timeout_d)) ptr_d = idx_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (pending_q[k]) sel_idx = 2'(k);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    clr       = '0;
    unique case (state_q)
      StIdle: begin
        if (sel_any) begin
          idx_d   = sel_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (ack) begin
          clr[idx_q] = 1'b1;
          valid_d    = 1'b0;
          state_d    = StIdle;
        end else if (HOLD_MAX != 0 && cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          // Expire on the edge that completes HOLD_MAX cycles of grant.
          timeout_d  = 1'b1;
          clr[idx_q] = 1'b1;
          valid_d    = 1'b0;
          state_d    = StIdle;
        end else if (HOLD_MAX != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A same-edge set overrides the clear so a re-asserted request re-arms.
    pending_d = pending_q & ~clr;
    if (enable) pending_d = pending_d | D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      pending_q <= pending_d;
    end
  end

  assign A       = idx_q[1];
  assign B       = idx_q[0];
  assign valid   = valid_q;
  assign pending = pending_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Directed bench for encoder_4x2_seq: vector table plus hand sequences for timeout,
// rotation and asynchronous reset mid-grant.
module tb_encoder_4x2_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ack = 1'b0;
  logic [0:3] D = '0;
  logic       A, B, valid, timeout;
  logic [0:3] pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  encoder_4x2_seq #(
    .HOLD_MAX(3),
    .CNT_W   (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .D      (D),
    .ack    (ack),
    .A      (A),
    .B      (B),
    .valid  (valid),
    .pending(pending),
    .timeout(timeout)
  );

  typedef struct {
    logic       en;
    logic [0:3] d;
    logic       ack;
    logic       valid;
    logic [1:0] ab;
    logic [0:3] pend;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic [0:3] d, input logic a, input logic v,
                     input logic [1:0] ab, input logic [0:3] p, input logic to);
    vec_t r;
    r.en = en; r.d = d; r.ack = a; r.valid = v; r.ab = ab; r.pend = p; r.to = to;
    vecs.push_back(r);
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [1:0] ab,
                         input logic [0:3] p, input logic to);
    chk({tag, " valid"}, 32'(valid), 32'(v));
    chk({tag, " AB"}, 32'({A, B}), 32'(ab));
    chk({tag, " pending"}, 32'(pending), 32'(p));
    chk({tag, " timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    logic [1:0] exp_idx;
    bit         seen;

    // Single request on D[2], grant then ack.
    add(1, 4'b0010, 0, 0, 2'b00, 4'b0010, 0);
    add(1, 4'b0000, 0, 1, 2'b10, 4'b0010, 0);
    add(0, 4'b0000, 1, 0, 2'b10, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 2'b10, 4'b0000, 0);
    // D[1] and D[3] together: index 1 first, bubble, then index 3.
    add(1, 4'b0101, 0, 0, 2'b10, 4'b0101, 0);
    add(0, 4'b0000, 0, 1, 2'b01, 4'b0101, 0);
    add(0, 4'b0000, 1, 0, 2'b01, 4'b0001, 0);
    add(0, 4'b0000, 0, 1, 2'b11, 4'b0001, 0);
    add(0, 4'b0000, 1, 0, 2'b11, 4'b0000, 0);
    // Capture disabled, stray acks ignored.
    for (int i = 0; i < 10; i++) add(0, 4'b1111, 1, 0, 2'b11, 4'b0000, 0);
    // Re-assert D[1] on the ack edge: set wins and index 1 is granted again.
    add(1, 4'b0100, 0, 0, 2'b11, 4'b0100, 0);
    add(0, 4'b0000, 0, 1, 2'b01, 4'b0100, 0);
    add(1, 4'b0100, 1, 0, 2'b01, 4'b0100, 0);
    add(0, 4'b0000, 0, 1, 2'b01, 4'b0100, 0);
    add(0, 4'b0000, 1, 0, 2'b01, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 2'b01, 4'b0000, 0);

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 2'b00, 4'b0000, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      enable = vecs[i].en;
      D      = vecs[i].d;
      ack    = vecs[i].ack;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].ab, vecs[i].pend, vecs[i].to);
    end

    // Timeout with HOLD_MAX=3 on a lone D[0] request.
    enable = 1'b1; D = 4'b1000; ack = 1'b0;
    step();
    chk_all("to_cap", 0, 2'b01, 4'b1000, 0);
    enable = 1'b0; D = '0;
    step();
    chk_all("to_g0", 1, 2'b00, 4'b1000, 0);
    step();
    chk_all("to_g1", 1, 2'b00, 4'b1000, 0);
    step();
    chk_all("to_g2", 1, 2'b00, 4'b1000, 0);
    step();
    chk_all("to_exp", 0, 2'b00, 4'b0000, 1);
    step();
    chk_all("to_after", 0, 2'b00, 4'b0000, 0);

    // Fresh reset so the rotate pointer starts at 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    enable = 1'b1; D = 4'b1111; ack = 1'b0;
    for (int g = 0; g < 5; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
        step();
        seen = valid;
      end
      chk($sformatf("rr%0d grant seen", g), 32'(seen), 32'(1));
`ifdef ENC_ROUND_ROBIN_EN
      exp_idx = 2'(g % 4);
`else
      exp_idx = 2'b00;
`endif
      chk($sformatf("rr%0d index", g), 32'({A, B}), 32'(exp_idx));
      ack = 1'b1;
      step();
      chk($sformatf("rr%0d valid after ack", g), 32'(valid), 32'(0));
      ack = 1'b0;
    end

    // Async reset in the middle of a grant.
    enable = 1'b0; D = '0;
    step();
    chk("mid grant valid", 32'(valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 2'b00, 4'b0000, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("post_rst%0d", i), 0, 2'b00, 4'b0000, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
